eater_cpu: RTL

Parametrised SAP-style CPU core: the next-generation replacement for the fixed 8-bit core behind the TinyTapeout top wrapper. It contains program/data RAM, A/B registers, ALU with carry/zero flags, a variable-length microsequencer and an internal tick divider. While in programming mode it accepts RAM writes from the pads; otherwise it runs the stored program. The top wrapper instantiates it directly in place of the old core.

---
 rtl/eater_pkg.sv | 29 ++
 rtl/eater_ram.sv | 24 ++
 rtl/eater_cpu.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/eater_pkg.sv
// Shared types for the eater_cpu core: opcode and microsequencer state encodings.
package eater_pkg;

  localparam int OPC_W = 4;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    T0   = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    T4   = 3'd4,
    HALT = 3'd5
  } state_t;

endpackage

// File: rtl/eater_ram.sv
// Program/data RAM: one synchronous write port, asynchronous read.
// Contents carry no reset; only writes change them.
module eater_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write port: a single write per edge.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/eater_cpu.sv
// SAP-style CPU core: RAM, A/B registers, ALU with carry/zero flags,
// a variable-length microsequencer (T0..T4, HALT) and a tick divider.
// DATA_W must be at least 4 + ADDR_W; CLK_DIV must be at least 1.
// While prog_mode is high the core is held at T0 and RAM can be loaded from the pads.
module eater_cpu
  import eater_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int CLK_DIV = 1
) (
  input  logic              fastClk,
  input  logic              rst,
  input  logic              prog_mode,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              halted,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] bus_oe
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IMM_W = DATA_W - OPC_W;

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic              tick;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic              c_flag;
  logic              z_flag;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W:0]   alu_res;

  opcode_t           op;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W-1:0] imm;

  logic              prog_wr;
  logic              sta_wr;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;

  // A + B, or A + ~B + 1 for subtraction; bit DATA_W is the carry out.
  function automatic logic [DATA_W:0] alu(input logic [DATA_W-1:0] lhs,
                                          input logic [DATA_W-1:0] rhs,
                                          input logic              sub);
    logic [DATA_W-1:0] opnd;
    opnd = sub ? ~rhs : rhs;
    return {1'b0, lhs} + {1'b0, opnd} + {{DATA_W{1'b0}}, sub};
  endfunction

  assign tick    = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign op      = opcode_t'(ir[DATA_W-1 -: OPC_W]);
  assign operand = ir[ADDR_W-1:0];
  assign imm     = {{OPC_W{1'b0}}, ir[IMM_W-1:0]};
  assign alu_res = alu(a_reg, b_reg, op == OP_SUB);
  assign bus_oe  = prog_mode ? '0 : '1;

  // The RAM write port is shared: pad loading in programming mode, STA otherwise.
  // Neither path writes on a reset edge, so an aborted STA leaves RAM untouched.
  assign prog_wr   = !rst && prog_mode && prog_we;
  assign sta_wr    = !rst && !prog_mode && tick && (state == T3) && (op == OP_STA);
  assign ram_we    = prog_wr || sta_wr;
  assign ram_waddr = prog_mode ? prog_addr : mar;
  assign ram_wdata = prog_mode ? prog_data : a_reg;

  eater_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (fastClk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (mar),
    .rdata (ram_rdata)
  );

  // Tick divider: counts 0..CLK_DIV-1 and wraps on the tick cycle.
  always_ff @(posedge fastClk) begin
    if (rst || prog_mode) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Microsequencer with registered outputs; advances one state per tick.
  // Reset clears control state only; A, B, flags, IR and MAR are cleared by programming mode.
  always_ff @(posedge fastClk) begin
    if (rst) begin
      state     <= T0;
      pc        <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      halted    <= 1'b0;
    end else if (prog_mode) begin
      state     <= T0;
      pc        <= '0;
      mar       <= '0;
      ir        <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      c_flag    <= 1'b0;
      z_flag    <= 1'b0;
      halted    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (tick) begin
        case (state)
          T0: begin
            mar   <= pc;
            state <= T1;
          end
          T1: begin
            ir    <= ram_rdata;
            pc    <= pc + 1'b1;
            state <= T2;
          end
          T2: begin
            state <= T0;
            case (op)
              OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                mar   <= operand;
                state <= T3;
              end
              OP_LDI: a_reg <= imm;
              OP_JMP: pc <= operand;
              OP_JC:  if (c_flag) pc <= operand;
              OP_JZ:  if (z_flag) pc <= operand;
              OP_OUT: begin
                out_data  <= a_reg;
                out_valid <= 1'b1;
              end
              OP_HLT: begin
                state  <= HALT;
                halted <= 1'b1;
              end
              default: ;
            endcase
          end
          T3: begin
            state <= T0;
            case (op)
              OP_LDA: a_reg <= ram_rdata;
              OP_ADD, OP_SUB: begin
                b_reg <= ram_rdata;
                state <= T4;
              end
              default: ;
            endcase
          end
          T4: begin
            a_reg  <= alu_res[DATA_W-1:0];
            c_flag <= alu_res[DATA_W];
            z_flag <= (alu_res[DATA_W-1:0] == '0);
            state  <= T0;
          end
          HALT:    state <= HALT;
          default: state <= T0;
        endcase
      end
    end
  end

endmodule
